anton_neopixel_stream: RTL and testbench

ANTON_NEOPIXEL_STREAM -- requirements
Module: anton_neopixel_stream

---
 rtl/anton_neopixel_stream_pkg.sv | 22 ++
 rtl/anton_neopixel_bit_timer.sv | 46 ++++
 rtl/anton_neopixel_stream.sv | 163 ++++++++++++++++
 tb/tb_anton_neopixel_stream.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/anton_neopixel_stream_pkg.sv
// Shared types, timing defaults and helpers for the NeoPixel frame streamer.
package anton_neopixel_stream_pkg;

    localparam int unsigned BUFFER_END_DEFAULT = 255;
    localparam int unsigned T0H_DEFAULT        = 20;
    localparam int unsigned T1H_DEFAULT        = 40;
    localparam int unsigned TBIT_DEFAULT       = 63;
    localparam int unsigned TRESET_DEFAULT     = 2500;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPrefetch = 2'd1,
        StBit      = 2'd2,
        StLatch    = 2'd3
    } stream_state_e;

    // Ceiling log2 that never returns zero, so derived vectors stay legal.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/anton_neopixel_bit_timer.sv
// Bit-period counter: registered high/low level for the serial line plus bit-boundary strobes.
module anton_neopixel_bit_timer
    import anton_neopixel_stream_pkg::*;
#(
    parameter int unsigned T0H  = T0H_DEFAULT,
    parameter int unsigned T1H  = T1H_DEFAULT,
    parameter int unsigned TBIT = TBIT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_en_next,
    input  logic i_one_next,
    output logic o_high,
    output logic o_first,
    output logic o_last
);

    localparam int unsigned CW = clog2_min1(TBIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TBIT - 1);
    localparam logic [CW-1:0] HI_ZERO  = CW'(T0H);
    localparam logic [CW-1:0] HI_ONE   = CW'(T1H);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_high;

    assign w_cnt_next = (i_en && (r_cnt != CNT_LAST)) ? r_cnt + CW'(1) : '0;

    // The level is computed from next-cycle count and bit value so the line is glitch-free
    // and stays aligned with the counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_high <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_high <= i_en_next && (w_cnt_next < (i_one_next ? HI_ONE : HI_ZERO));
        end
    end

    assign o_high  = r_high;
    assign o_first = i_en && (r_cnt == '0);
    assign o_last  = i_en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/anton_neopixel_stream.sv
// Streams raw buffer bytes from a two-port RAM as a NeoPixel waveform, one frame per run
// request, followed by a low latch period and a one-cycle end-of-frame pulse.
module anton_neopixel_stream
    import anton_neopixel_stream_pkg::*;
#(
    parameter int unsigned BUFFER_END = BUFFER_END_DEFAULT,
    parameter int unsigned T0H        = T0H_DEFAULT,
    parameter int unsigned T1H        = T1H_DEFAULT,
    parameter int unsigned TBIT       = TBIT_DEFAULT,
    parameter int unsigned TRESET     = TRESET_DEFAULT,
    localparam int unsigned BUFFER_BITS = clog2_min1(BUFFER_END + 1)
) (
    input  logic                   busClk,
    input  logic                   busRst,
    output logic [BUFFER_BITS-1:0] pixelIxComb,
    input  logic [7:0]             pixelByte,
    input  logic [12:0]            regMax,
    input  logic                   regCtrlLimit,
    input  logic                   regCtrlRun,
    input  logic                   regCtrl32bit,
    output logic                   neoData,
    output logic                   state,
    output logic                   streamSyncOf
);

    localparam int unsigned LW = clog2_min1(TRESET);
    localparam logic [LW-1:0] LATCH_LAST = LW'(TRESET - 1);
    localparam logic [BUFFER_BITS-1:0] END_IX = BUFFER_BITS'(BUFFER_END);
    localparam logic [31:0] IX_MASK = (32'd1 << BUFFER_BITS) - 32'd1;

    stream_state_e          r_state;
    logic                   r_busy;
    logic                   r_sync;
    logic [BUFFER_BITS-1:0] r_ix;
    logic [BUFFER_BITS-1:0] r_last;
    logic                   r_mode32;
    logic [7:0]             r_shift;
    logic [2:0]             r_bitcnt;
    logic                   r_final;
    logic [LW-1:0]          r_lcnt;

    logic                   w_bit_first;
    logic                   w_bit_last;
    logic                   w_high;
    logic                   w_frame_end;
    logic                   w_en_next;
    logic                   w_one_next;
    logic [31:0]            w_max_wide;
    logic                   w_unused_max;
    logic [BUFFER_BITS-1:0] w_last_sel;
    logic [BUFFER_BITS:0]   w_ix_inc;
    logic [BUFFER_BITS:0]   w_ix_next;
    logic                   w_done;

    // regMax bits above the buffer address width are ignored by design.
    assign w_max_wide   = {19'd0, regMax};
    assign w_unused_max = ^(w_max_wide & ~IX_MASK);
    assign w_last_sel   = (regCtrlLimit && (w_max_wide[BUFFER_BITS-1:0] < END_IX))
                        ? w_max_wide[BUFFER_BITS-1:0] : END_IX;

    // In 32-bit mode the fourth byte of every pixel is never sent.
    assign w_ix_inc  = {1'b0, r_ix} + (BUFFER_BITS + 1)'(1);
    assign w_ix_next = (r_mode32 && (w_ix_inc[1:0] == 2'b11))
                     ? w_ix_inc + (BUFFER_BITS + 1)'(1) : w_ix_inc;
    assign w_done    = w_ix_next > {1'b0, r_last};

    assign w_frame_end = (r_state == StBit) && w_bit_last && (r_bitcnt == 3'd0) && r_final;
    assign w_en_next   = (r_state == StPrefetch) || ((r_state == StBit) && !w_frame_end);

    always_comb begin
        w_one_next = r_shift[7];
        if (r_state == StPrefetch) begin
            w_one_next = pixelByte[7];
        end else if (w_bit_last) begin
            w_one_next = (r_bitcnt == 3'd0) ? pixelByte[7] : r_shift[6];
        end
    end

    anton_neopixel_bit_timer #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_timer (
        .i_clk      (busClk),
        .i_rst      (busRst),
        .i_en       (r_state == StBit),
        .i_en_next  (w_en_next),
        .i_one_next (w_one_next),
        .o_high     (w_high),
        .o_first    (w_bit_first),
        .o_last     (w_bit_last)
    );

    always_ff @(posedge busClk) begin
        if (busRst) begin
            r_state  <= StIdle;
            r_busy   <= 1'b0;
            r_sync   <= 1'b0;
            r_ix     <= '0;
            r_last   <= '0;
            r_mode32 <= 1'b0;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_final  <= 1'b0;
            r_lcnt   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (regCtrlRun) begin
                        r_state  <= StPrefetch;
                        r_busy   <= 1'b1;
                        r_last   <= w_last_sel;
                        r_mode32 <= regCtrl32bit;
                        r_final  <= 1'b0;
                    end
                end
                StPrefetch: begin
                    r_shift  <= pixelByte;
                    r_bitcnt <= 3'd7;
                    r_state  <= StBit;
                end
                StBit: begin
                    // Fetch the next byte early so it is ready by the end of bit 0.
                    if (w_bit_first && (r_bitcnt == 3'd0)) begin
                        r_ix    <= w_ix_next[BUFFER_BITS-1:0];
                        r_final <= w_done;
                    end
                    if (w_bit_last) begin
                        if (r_bitcnt != 3'd0) begin
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_bitcnt <= r_bitcnt - 3'd1;
                        end else if (r_final) begin
                            r_state <= StLatch;
                            r_ix    <= '0;
                            r_lcnt  <= '0;
                            r_sync  <= (TRESET == 1);
                        end else begin
                            r_shift  <= pixelByte;
                            r_bitcnt <= 3'd7;
                        end
                    end
                end
                StLatch: begin
                    if (r_lcnt == LATCH_LAST) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_sync  <= 1'b0;
                    end else begin
                        r_lcnt <= r_lcnt + LW'(1);
                        r_sync <= ((r_lcnt + LW'(1)) == LATCH_LAST);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign pixelIxComb  = r_ix;
    assign neoData      = w_high;
    assign state        = r_busy;
    assign streamSyncOf = r_sync;

endmodule

// File: tb/tb_anton_neopixel_stream.sv
// Randomised frame bench: decodes the serial waveform and compares it with a byte-list model.
module tb_anton_neopixel_stream;

    localparam int T0H = 2, T1H = 4, TBIT = 6, TRESET = 20, BE = 7;

    logic        clk = 1'b0;
    logic        busRst, regCtrlRun, regCtrlLimit, regCtrl32bit;
    logic        neoData, state, streamSyncOf;
    logic [12:0] regMax;
    logic [2:0]  pixelIxComb;
    logic [7:0]  pixelByte;
    logic [7:0]  ram [0:7];

    int errors = 0, checks = 0;
    int cap_neo[$], cap_ix[$], cap_sync[$];
    int cap_wait;
    bit cap_to;
    int chg_at;
    int exp_ix[$], got_hi[$], got_rise[$], got_addr[$];

    always #5 clk = ~clk;

    always @(posedge clk) pixelByte <= ram[pixelIxComb];

    anton_neopixel_stream #(
        .BUFFER_END (BE),
        .T0H        (T0H),
        .T1H        (T1H),
        .TBIT       (TBIT),
        .TRESET     (TRESET)
    ) dut (
        .busClk       (clk),
        .busRst       (busRst),
        .pixelIxComb  (pixelIxComb),
        .pixelByte    (pixelByte),
        .regMax       (regMax),
        .regCtrlLimit (regCtrlLimit),
        .regCtrlRun   (regCtrlRun),
        .regCtrl32bit (regCtrl32bit),
        .neoData      (neoData),
        .state        (state),
        .streamSyncOf (streamSyncOf)
    );

    // Records one busy period (state==1) sample by sample; no checking here.
    task automatic capture(input bit drop_run);
        cap_neo.delete(); cap_ix.delete(); cap_sync.delete();
        cap_to = 0; cap_wait = 0;
        do begin
            @(negedge clk); cap_wait++;
        end while (state !== 1'b1 && cap_wait < 2000);
        if (state !== 1'b1) begin cap_to = 1; return; end
        if (drop_run) regCtrlRun = 1'b0;
        while (state === 1'b1 && cap_neo.size() < 2000) begin
            cap_neo.push_back(int'(neoData));
            cap_ix.push_back(int'(pixelIxComb));
            cap_sync.push_back(int'(streamSyncOf));
            if (cap_neo.size() == chg_at) begin
                regCtrlLimit = ~regCtrlLimit; regMax = 13'd0; regCtrl32bit = ~regCtrl32bit;
            end
            @(negedge clk);
        end
        if (state === 1'b1) cap_to = 1;
    endtask

    // Bytes sent in a frame: indices 0..last, skipping the fourth byte of each pixel in 32-bit mode.
    function automatic void build_model(input logic lim, input int mx, input logic m32);
        int last;
        last = lim ? (mx % 8) : BE;
        if (last > BE) last = BE;
        exp_ix.delete();
        for (int i = 0; i <= last; i++) if (!(m32 && (i % 4) == 3)) exp_ix.push_back(i);
    endfunction

    function automatic void decode();
        got_hi.delete(); got_rise.delete(); got_addr.delete();
        for (int i = 0; i < cap_neo.size(); i++) begin
            if (cap_neo[i] == 1 && (i == 0 || cap_neo[i-1] == 0)) begin
                got_rise.push_back(i); got_hi.push_back(0);
            end
            if (cap_neo[i] == 1 && got_hi.size() > 0) got_hi[got_hi.size()-1]++;
            if (i == 0 || cap_ix[i] != cap_ix[i-1]) got_addr.push_back(cap_ix[i]);
        end
    endfunction

    task automatic test_reset();
        busRst = 1'b1; regCtrlRun = 1'b0; regCtrlLimit = 1'b0; regCtrl32bit = 1'b0; regMax = '0;
        repeat (3) @(negedge clk);
        checks++; if (neoData !== 1'b0) begin errors++; $display("FAIL reset neoData: got %b expected 0", neoData); end
        checks++; if (state !== 1'b0) begin errors++; $display("FAIL reset state: got %b expected 0", state); end
        checks++; if (streamSyncOf !== 1'b0) begin errors++; $display("FAIL reset sync: got %b expected 0", streamSyncOf); end
        checks++; if (pixelIxComb !== 3'd0) begin errors++; $display("FAIL reset addr: got %0d expected 0", pixelIxComb); end
        busRst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (state !== 1'b0 || neoData !== 1'b0) begin
            errors++; $display("FAIL idle without run: got state=%b neo=%b expected 0 0", state, neoData);
        end
    endtask

    task automatic test_frames();
        logic lim, m32;
        int   mx, nb, sc, bitv, ehi, n;
        for (int f = 0; f < 10; f++) begin
            chg_at = -1;
            case (f)
                0: begin lim = 0; mx = 0;  m32 = 0; end
                1: begin lim = 1; mx = 2;  m32 = 0; end
                2: begin lim = 1; mx = 12; m32 = 0; end
                3: begin lim = 0; mx = 0;  m32 = 1; end
                4: begin lim = 1; mx = 3;  m32 = 1; end
                5: begin lim = 0; mx = 0;  m32 = 0; chg_at = 100; end
                default: begin lim = 1'($urandom); mx = int'($urandom_range(15)); m32 = 1'($urandom); end
            endcase
            for (int i = 0; i < 8; i++) ram[i] = 8'($urandom);
            if (f == 0) ram[0] = 8'hA5;
            regCtrlLimit = lim; regMax = 13'(mx); regCtrl32bit = m32; regCtrlRun = 1'b1;
            capture(1);
            build_model(lim, mx, m32);
            decode();
            nb = exp_ix.size();
            checks++; if (cap_to) begin errors++; $display("FAIL frame%0d timeout: got 1 expected 0", f); end
            checks++; if (cap_neo.size() != 1 + nb * 8 * TBIT + TRESET) begin
                errors++; $display("FAIL frame%0d busy cycles: got %0d expected %0d", f, cap_neo.size(),
                                   1 + nb * 8 * TBIT + TRESET);
            end
            checks++; if (got_rise.size() != nb * 8) begin
                errors++; $display("FAIL frame%0d bit count: got %0d expected %0d", f, got_rise.size(), nb * 8);
            end
            n = (got_rise.size() < nb * 8) ? got_rise.size() : nb * 8;
            for (int k = 0; k < n; k++) begin
                bitv = int'(ram[exp_ix[k/8]][7 - k % 8]);
                ehi = bitv ? T1H : T0H;
                checks++; if (got_hi[k] != ehi) begin
                    errors++; $display("FAIL frame%0d bit%0d high: got %0d expected %0d", f, k, got_hi[k], ehi);
                end
                checks++; if (got_rise[k] != 1 + k * TBIT) begin
                    errors++; $display("FAIL frame%0d bit%0d start: got %0d expected %0d", f, k, got_rise[k],
                                       1 + k * TBIT);
                end
            end
            sc = 0;
            foreach (cap_sync[i]) sc += cap_sync[i];
            checks++; if (sc != 1) begin errors++; $display("FAIL frame%0d sync count: got %0d expected 1", f, sc); end
            checks++; if (cap_sync.size() == 0 || cap_sync[cap_sync.size()-1] != 1) begin
                errors++; $display("FAIL frame%0d sync on last cycle: got 0 expected 1", f);
            end
            checks++; if (got_addr.size() < nb) begin
                errors++; $display("FAIL frame%0d address count: got %0d expected >=%0d", f, got_addr.size(), nb);
            end else begin
                for (int k = 0; k < nb; k++) begin
                    checks++; if (got_addr[k] != exp_ix[k]) begin
                        errors++; $display("FAIL frame%0d addr%0d: got %0d expected %0d", f, k, got_addr[k], exp_ix[k]);
                    end
                end
            end
            repeat (3) @(negedge clk);
            checks++; if (state !== 1'b0) begin errors++; $display("FAIL frame%0d restart: got 1 expected 0", f); end
        end
    endtask

    task automatic test_back_to_back();
        int sc, len;
        for (int i = 0; i < 8; i++) ram[i] = 8'($urandom);
        regCtrlLimit = 1'b1; regMax = 13'd1; regCtrl32bit = 1'b0; regCtrlRun = 1'b1;
        len = 1 + 2 * 8 * TBIT + TRESET;
        for (int fr = 0; fr < 2; fr++) begin
            capture(0);
            decode();
            if (fr == 1) begin
                checks++; if (cap_wait != 1) begin
                    errors++; $display("FAIL b2b idle gap: got %0d expected 1", cap_wait);
                end
            end
            checks++; if (cap_to || cap_neo.size() != len) begin
                errors++; $display("FAIL b2b%0d busy cycles: got %0d expected %0d", fr, cap_neo.size(), len);
            end
            sc = 0;
            foreach (cap_sync[i]) sc += cap_sync[i];
            checks++; if (sc != 1) begin errors++; $display("FAIL b2b%0d sync count: got %0d expected 1", fr, sc); end
            checks++; if (got_rise.size() != 16) begin
                errors++; $display("FAIL b2b%0d bit count: got %0d expected 16", fr, got_rise.size());
            end
        end
        regCtrlRun = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (state !== 1'b0) begin errors++; $display("FAIL b2b stop: got 1 expected 0"); end
    endtask

    task automatic test_reset_abort();
        int  stop_at, w;
        bit  seen_sync, seen_busy;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 8; i++) ram[i] = 8'($urandom);
            regCtrl32bit = 1'b0; regCtrlLimit = (c == 1); regMax = 13'd0;
            stop_at = (c == 0) ? 1 + 13 * TBIT : 1 + 8 * TBIT + 5;
            regCtrlRun = 1'b1;
            w = 0;
            do begin @(negedge clk); w++; end while (state !== 1'b1 && w < 2000);
            regCtrlRun = 1'b0;
            checks++; if (state !== 1'b1) begin errors++; $display("FAIL abort%0d start: got 0 expected 1", c); end
            repeat (stop_at) @(negedge clk);
            busRst = 1'b1;
            @(negedge clk);
            checks++; if (neoData !== 1'b0) begin errors++; $display("FAIL abort%0d neoData: got %b expected 0", c, neoData); end
            checks++; if (state !== 1'b0) begin errors++; $display("FAIL abort%0d state: got %b expected 0", c, state); end
            checks++; if (pixelIxComb !== 3'd0) begin
                errors++; $display("FAIL abort%0d addr: got %0d expected 0", c, pixelIxComb);
            end
            busRst = 1'b0;
            seen_sync = (streamSyncOf !== 1'b0); seen_busy = 0;
            repeat (40) begin
                @(negedge clk);
                if (streamSyncOf !== 1'b0) seen_sync = 1;
                if (state !== 1'b0) seen_busy = 1;
            end
            checks++; if (seen_sync || seen_busy) begin
                errors++; $display("FAIL abort%0d quiet after reset: got sync=%0d busy=%0d expected 0 0", c,
                                   seen_sync, seen_busy);
            end
        end
    endtask

    initial begin
        chg_at = -1;
        for (int i = 0; i < 8; i++) ram[i] = 8'h00;
        test_reset();
        test_frames();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
